alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu.sv | 38 +++
 rtl/alu_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-port ALU arbiter.
// Provides the datapath width, the 5-bit opcode encodings and the
// requester port ids. The opcode range check is also kept here so the
// arbiter and the ALU agree on which opcodes are legal.
package alu_pkg;

  localparam int XLEN = 32;

  // Opcode encodings
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLT    = 5'd5;
  localparam logic [4:0] ALU_SLTU   = 5'd6;
  localparam logic [4:0] ALU_UPPERA = 5'd7;  // A with its low 12 bits cleared
  localparam logic [4:0] ALU_AUIPC  = 5'd8;  // A + (B with low 12 bits cleared)
  localparam logic [4:0] ALU_LUI    = 5'd9;  // B with its low 12 bits cleared
  localparam logic [4:0] ALU_OP_MAX = 5'd9;

  // Requester port ids
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Mask that clears the 12-bit immediate field of an upper-immediate value.
  localparam logic [XLEN-1:0] UPPER_MASK = 32'hFFFF_F000;

  function automatic logic op_illegal(input logic [4:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU.
// Ports:
//   a, b    in  32  operands
//   op      in  5   opcode (see alu_pkg)
//   result  out 32  ALU result; 0 for any opcode outside the legal range
//   zero    out 1   result equals zero
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // NOTE: every output of a combinational block gets a default before the
  // case so that no path leaves it unassigned (which would infer a latch).
  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'd0, a < b};
      ALU_UPPERA: result = a & UPPER_MASK;
      ALU_AUIPC:  result = a + (b & UPPER_MASK);
      ALU_LUI:    result = b & UPPER_MASK;
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU.
// A request accepted on either port is registered in stage 1 (operand
// register, which feeds the ALU), then moved to stage 2 (response register)
// where it is held until the consumer takes it. Fully pipelined: one request
// per cycle with resp_ready high.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   reqN_valid/ready             request handshake, port N (0 or 1)
//   reqN_a, reqN_b, reqN_op      operands and opcode, port N
//   resp_valid/ready             response handshake
//   resp_id                      port that issued the request
//   resp_result, resp_zero       ALU result and zero flag (0 on illegal op)
//   resp_err                     opcode was illegal (> 9)
module alu_arbiter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [4:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [4:0]      req1_op,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero,
  output logic            resp_err
);

  logic            last_grant;
  logic            grant0, grant1;
  logic            s1_valid, s1_id, s1_err;
  logic [XLEN-1:0] s1_a, s1_b;
  logic [4:0]      s1_op;
  logic            s1_free, s2_free;
  logic            accept, acc_id;
  logic [XLEN-1:0] acc_a, acc_b;
  logic [4:0]      acc_op;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // Round robin: a lone requester always wins; on a tie the port that was
  // not granted last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant == PORT1);
  assign grant1 = req1_valid && (!req0_valid || last_grant == PORT0);

  assign s2_free = !resp_valid || resp_ready;
  assign s1_free = !s1_valid || s2_free;

  // Ready is forced low during reset so nothing is accepted on the reset edge.
  assign req0_ready = reset_n && grant0 && s1_free;
  assign req1_ready = reset_n && grant1 && s1_free;

  // Grants are mutually exclusive, so the port 1 ready alone selects the source.
  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign acc_id = req1_ready ? PORT1 : PORT0;
  assign acc_a  = req1_ready ? req1_a  : req0_a;
  assign acc_b  = req1_ready ? req1_b  : req0_b;
  assign acc_op = req1_ready ? req1_op : req0_op;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which the same-edge drain/move/accept relies on.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= PORT1;
      s1_valid   <= 1'b0;
      s1_id      <= PORT0;
      s1_err     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= ALU_ADD;
    end else if (accept) begin
      last_grant <= acc_id;
      s1_valid   <= 1'b1;
      s1_id      <= acc_id;
      s1_err     <= op_illegal(acc_op);
      s1_a       <= acc_a;
      s1_b       <= acc_b;
      s1_op      <= acc_op;
    end else if (s2_free) begin
      // Stage 1 drains into stage 2 (or was already empty).
      s1_valid <= 1'b0;
    end
  end

  alu u_alu (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_valid  <= 1'b0;
      resp_id     <= PORT0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if (s1_valid && s2_free) begin
      resp_valid  <= 1'b1;
      resp_id     <= s1_id;
      resp_result <= s1_err ? '0 : alu_result;
      resp_zero   <= s1_err ? 1'b0 : alu_zero;
      resp_err    <= s1_err;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
